// File: rtl/mem_access_stage_if.sv
// Data-memory split-handshake port: request phase (addr_ok) and response phase (data_ok).
interface mem_access_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                    dmem_req_o;
  logic                    dmem_we_o;
  logic [ADDR_WIDTH-1:0]   dmem_addr_o;
  logic [DATA_WIDTH/8-1:0] dmem_wstrb_o;
  logic [DATA_WIDTH-1:0]   dmem_wdata_o;
  logic                    dmem_addr_ok_i;
  logic                    dmem_data_ok_i;
  logic [DATA_WIDTH-1:0]   dmem_rdata_i;

  // Pipeline stage side.
  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o,
    input  dmem_addr_ok_i, dmem_data_ok_i, dmem_rdata_i
  );

  // Memory side.
  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o,
    output dmem_addr_ok_i, dmem_data_ok_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: forwards the writeback triple from EX to WB and performs
// loads/stores over a split-handshake data-memory port, with misalignment detection.
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid_i,
  output logic                      ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] wd_i,
  input  logic                      wreg_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic                      mem_en_i,
  input  logic                      mem_we_i,
  input  logic [1:0]                mem_size_i,
  input  logic                      mem_signed_i,
  input  logic [ADDR_WIDTH-1:0]     mem_addr_i,
  input  logic [DATA_WIDTH-1:0]     mem_wdata_i,
  mem_access_stage_if.master        dmem,
  input  logic                      wb_allowin_i,
  output logic                      valid_o,
  output logic [REG_ADDR_WIDTH-1:0] wd_o,
  output logic                      wreg_o,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic                      ale_o,
  output logic [ADDR_WIDTH-1:0]     badv_o
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e                    state_q, state_d;
  logic                      valid_q, valid_d;
  logic [REG_ADDR_WIDTH-1:0] wd_q, wd_d;
  logic                      wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      ale_q, ale_d;
  logic [ADDR_WIDTH-1:0]     badv_q, badv_d;
  logic                      req_q, req_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [NB-1:0]             wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]     bwdata_q, bwdata_d;
  logic [REG_ADDR_WIDTH-1:0] op_wd_q, op_wd_d;
  logic                      op_wreg_q, op_wreg_d;
  logic [1:0]                op_size_q, op_size_d;
  logic                      op_signed_q, op_signed_d;

  logic                      accept;
  logic                      misaligned;
  logic [7:0]                mask8;
  logic [NB-1:0]             in_strb;
  logic [DATA_WIDTH-1:0]     in_bwdata;
  logic [DATA_WIDTH-1:0]     shifted;
  logic [DATA_WIDTH-1:0]     keep;
  logic                      sbit;
  logic [DATA_WIDTH-1:0]     load_data;

  assign ready_o = (state_q == StIdle) && (!valid_q || wb_allowin_i);
  assign accept  = ex_valid_i && ready_o;

  // Alignment check; a double access on a 32-bit datapath is always treated as misaligned.
  always_comb begin
    misaligned = 1'b0;
    case (mem_size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = mem_addr_i[0];
      2'b10:   misaligned = |mem_addr_i[1:0];
      default: misaligned = (DATA_WIDTH == 32) ? 1'b1 : |mem_addr_i[2:0];
    endcase
  end

  // Store strobes and lane-replicated store data for the incoming op.
  always_comb begin
    int unsigned sz_bytes;
    sz_bytes = 32'd1 << mem_size_i;
    case (mem_size_i)
      2'b00:   mask8 = 8'h01;
      2'b01:   mask8 = 8'h03;
      2'b10:   mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
    in_strb   = mask8[NB-1:0] << mem_addr_i[OFF_W-1:0];
    in_bwdata = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      in_bwdata[8*i +: 8] = mem_wdata_i[8*(i & (sz_bytes - 1)) +: 8];
    end
  end

  // Load data: shift the addressed lane down, truncate to size, then extend.
  always_comb begin
    shifted = dmem.dmem_rdata_i >> {addr_q[OFF_W-1:0], 3'b000};
    case (op_size_q)
      2'b00: begin
        keep = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 8);
        sbit = shifted[7];
      end
      2'b01: begin
        keep = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 16);
        sbit = shifted[15];
      end
      2'b10: begin
        keep = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 32);
        sbit = shifted[31];
      end
      default: begin
        keep = {DATA_WIDTH{1'b1}};
        sbit = shifted[DATA_WIDTH-1];
      end
    endcase
    load_data = (shifted & keep) | ((op_signed_q && sbit) ? ~keep : '0);
  end

  // Next-state: FSM, bus request registers and output register.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    ale_d       = ale_q;
    badv_d      = badv_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    bwdata_d    = bwdata_q;
    op_wd_d     = op_wd_q;
    op_wreg_d   = op_wreg_q;
    op_size_d   = op_size_q;
    op_signed_d = op_signed_q;

    // WB consumed the output; a completion below overrides this clear.
    if (valid_q && wb_allowin_i) begin
      valid_d = 1'b0;
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      ale_d   = 1'b0;
      badv_d  = '0;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (!mem_en_i) begin
            valid_d = 1'b1;
            wd_d    = wd_i;
            wreg_d  = wreg_i;
            wdata_d = wdata_i;
            ale_d   = 1'b0;
            badv_d  = '0;
          end else if (misaligned) begin
            valid_d = 1'b1;
            wd_d    = wd_i;
            wreg_d  = 1'b0;
            wdata_d = '0;
            ale_d   = 1'b1;
            badv_d  = mem_addr_i;
          end else begin
            req_d       = 1'b1;
            we_d        = mem_we_i;
            addr_d      = mem_addr_i;
            wstrb_d     = mem_we_i ? in_strb : '0;
            bwdata_d    = mem_we_i ? in_bwdata : '0;
            op_wd_d     = wd_i;
            op_wreg_d   = wreg_i;
            op_size_d   = mem_size_i;
            op_signed_d = mem_signed_i;
            state_d     = StReq;
          end
        end
      end
      StReq: begin
        if (dmem.dmem_addr_ok_i) begin
          req_d   = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        // Output register is guaranteed free here, so data_ok is always captured.
        if (dmem.dmem_data_ok_i) begin
          state_d = StIdle;
          valid_d = 1'b1;
          wd_d    = op_wd_q;
          wreg_d  = !we_q && op_wreg_q;
          wdata_d = we_q ? '0 : load_data;
          ale_d   = 1'b0;
          badv_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= 1'b0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      wdata_q     <= '0;
      ale_q       <= 1'b0;
      badv_q      <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wstrb_q     <= '0;
      bwdata_q    <= '0;
      op_wd_q     <= '0;
      op_wreg_q   <= 1'b0;
      op_size_q   <= 2'b00;
      op_signed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      ale_q       <= ale_d;
      badv_q      <= badv_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wstrb_q     <= wstrb_d;
      bwdata_q    <= bwdata_d;
      op_wd_q     <= op_wd_d;
      op_wreg_q   <= op_wreg_d;
      op_size_q   <= op_size_d;
      op_signed_q <= op_signed_d;
    end
  end

  assign valid_o           = valid_q;
  assign wd_o              = wd_q;
  assign wreg_o            = wreg_q;
  assign wdata_o           = wdata_q;
  assign ale_o             = ale_q;
  assign badv_o            = badv_q;
  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_wstrb_o = wstrb_q;
  assign dmem.dmem_wdata_o = bwdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a 32-bit instance for most cases, a 64-bit one for
// double accesses and wide strobes.
module tb_mem_access_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  // 32-bit instance
  logic        ex_valid, wreg, mem_en, mem_we, mem_signed, wb_allowin;
  logic [4:0]  wd;
  logic [1:0]  mem_size;
  logic [31:0] wdata, mem_addr, mem_wdata;
  logic        ready, valid, wreg_out, ale;
  logic [4:0]  wd_out;
  logic [31:0] wdata_out, badv;

  mem_access_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) u_dut32 (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid), .ready_o(ready), .wd_i(wd), .wreg_i(wreg),
    .wdata_i(wdata), .mem_en_i(mem_en), .mem_we_i(mem_we), .mem_size_i(mem_size),
    .mem_signed_i(mem_signed), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .dmem(bus),
    .wb_allowin_i(wb_allowin), .valid_o(valid), .wd_o(wd_out), .wreg_o(wreg_out),
    .wdata_o(wdata_out), .ale_o(ale), .badv_o(badv)
  );

  // 64-bit instance
  logic        w_ex_valid, w_mem_en, w_mem_we;
  logic [1:0]  w_mem_size;
  logic [31:0] w_mem_addr;
  logic [63:0] w_mem_wdata;
  logic        w_ready, w_valid, w_wreg_out, w_ale;
  logic [4:0]  w_wd_out;
  logic [63:0] w_wdata_out;
  logic [31:0] w_badv;

  mem_access_stage_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) wbus ();

  mem_access_stage #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) u_dut64 (
    .clk(clk), .rst(rst), .ex_valid_i(w_ex_valid), .ready_o(w_ready), .wd_i(5'd12),
    .wreg_i(1'b1), .wdata_i(64'h0), .mem_en_i(w_mem_en), .mem_we_i(w_mem_we),
    .mem_size_i(w_mem_size), .mem_signed_i(1'b0), .mem_addr_i(w_mem_addr),
    .mem_wdata_i(w_mem_wdata), .dmem(wbus), .wb_allowin_i(1'b1), .valid_o(w_valid),
    .wd_o(w_wd_out), .wreg_o(w_wreg_out), .wdata_o(w_wdata_out), .ale_o(w_ale),
    .badv_o(w_badv)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [4:0] d, input logic [31:0] v);
    ex_valid = 1'b1; mem_en = 1'b0; wd = d; wreg = 1'b1; wdata = v;
  endtask

  // Issue one aligned 32-bit memory op; addr_ok after `delay` extra REQ cycles, data_ok next.
  task automatic mem_op(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rd,
                        input int delay, input logic [3:0] exp_strb, input logic [31:0] exp_bwd);
    ex_valid = 1'b1; mem_en = 1'b1; mem_we = we; mem_size = sz; mem_signed = sgn;
    mem_addr = addr; mem_wdata = sdata; wd = 5'd9; wreg = 1'b1; wdata = 32'hFFFF_FFFF;
    step();
    ex_valid = 1'b0; mem_en = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    for (int i = 0; i <= delay; i++) begin
      check_eq("req_valid", bus.dmem_req_o, 1);
      check_eq("req_addr", bus.dmem_addr_o, addr);
      check_eq("req_we", bus.dmem_we_o, we);
      check_eq("req_strb", bus.dmem_wstrb_o, exp_strb);
      if (we) check_eq("req_wdata", bus.dmem_wdata_o, exp_bwd);
      check_eq("busy_ready", ready, 0);
      // data_ok during REQ must be ignored.
      bus.dmem_addr_ok_i = (i == delay);
      bus.dmem_data_ok_i = 1'b1;
      bus.dmem_rdata_i   = 32'h5A5A_5A5A;
      step();
    end
    bus.dmem_addr_ok_i = 1'b0; bus.dmem_data_ok_i = 1'b0;
    check_eq("resp_req", bus.dmem_req_o, 0);
    check_eq("resp_valid", valid, 0);
    bus.dmem_data_ok_i = 1'b1; bus.dmem_rdata_i = rd;
    step();
    bus.dmem_data_ok_i = 1'b0; bus.dmem_rdata_i = 32'h0;
  endtask

  // 64-bit op with immediate handshake.
  task automatic w_mem_op(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [63:0] sdata, input logic [63:0] rd,
                          input logic [7:0] exp_strb, input logic [63:0] exp_bwd);
    w_ex_valid = 1'b1; w_mem_en = 1'b1; w_mem_we = we; w_mem_size = sz; w_mem_addr = addr;
    w_mem_wdata = sdata;
    step();
    w_ex_valid = 1'b0; w_mem_en = 1'b0;
    check_eq("w_req", wbus.dmem_req_o, 1);
    check_eq("w_req_addr", wbus.dmem_addr_o, addr);
    check_eq("w_req_strb", wbus.dmem_wstrb_o, exp_strb);
    if (we) check_eq("w_req_wdata", wbus.dmem_wdata_o, exp_bwd);
    wbus.dmem_addr_ok_i = 1'b1;
    step();
    wbus.dmem_addr_ok_i = 1'b0; wbus.dmem_data_ok_i = 1'b1; wbus.dmem_rdata_i = rd;
    step();
    wbus.dmem_data_ok_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 0; wreg = 0; mem_en = 0; mem_we = 0; mem_signed = 0; wb_allowin = 1;
    wd = 0; mem_size = 0; wdata = 0; mem_addr = 0; mem_wdata = 0;
    bus.dmem_addr_ok_i = 0; bus.dmem_data_ok_i = 0; bus.dmem_rdata_i = 0;
    w_ex_valid = 0; w_mem_en = 0; w_mem_we = 0; w_mem_size = 0; w_mem_addr = 0;
    w_mem_wdata = 0;
    wbus.dmem_addr_ok_i = 0; wbus.dmem_data_ok_i = 0; wbus.dmem_rdata_i = 0;
    repeat (2) step();

    // Reset state
    check_eq("rst_valid", valid, 0);
    check_eq("rst_wd", wd_out, 0);
    check_eq("rst_wreg", wreg_out, 0);
    check_eq("rst_wdata", wdata_out, 0);
    check_eq("rst_ale", ale, 0);
    check_eq("rst_badv", badv, 0);
    check_eq("rst_req", bus.dmem_req_o, 0);
    check_eq("rst_we", bus.dmem_we_o, 0);
    check_eq("rst_addr", bus.dmem_addr_o, 0);
    check_eq("rst_strb", bus.dmem_wstrb_o, 0);
    check_eq("rst_bwdata", bus.dmem_wdata_o, 0);
    check_eq("rst_w_valid", w_valid, 0);
    rst = 1'b0;
    #1;
    check_eq("rst_ready", ready, 1);

    // Non-memory op, then three back-to-back
    alu_op(5'd5, 32'h1234);
    step();
    check_eq("alu_valid", valid, 1);
    check_eq("alu_wd", wd_out, 5);
    check_eq("alu_wreg", wreg_out, 1);
    check_eq("alu_wdata", wdata_out, 32'h1234);
    check_eq("alu_ale", ale, 0);
    for (int k = 0; k < 3; k++) begin
      alu_op(5'(k + 1), 32'h100 + 32'(k));
      step();
      check_eq("b2b_valid", valid, 1);
      check_eq("b2b_wd", wd_out, 5'(k + 1));
      check_eq("b2b_wdata", wdata_out, 32'h100 + 32'(k));
    end
    ex_valid = 1'b0;
    step();
    check_eq("drain_valid", valid, 0);

    // Loads
    mem_op(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 32'h8000_0000, 0, 4'b0000, 32'h0);
    check_eq("lbs_valid", valid, 1);
    check_eq("lbs_wd", wd_out, 9);
    check_eq("lbs_wreg", wreg_out, 1);
    check_eq("lbs_wdata", wdata_out, 32'hFFFF_FF80);
    mem_op(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 32'h8000_0000, 0, 4'b0000, 32'h0);
    check_eq("lbu_wdata", wdata_out, 32'h0000_0080);
    mem_op(1'b0, 2'b01, 1'b1, 32'h1002, 32'h0, 32'h8001_0000, 0, 4'b0000, 32'h0);
    check_eq("lhs_wdata", wdata_out, 32'hFFFF_8001);
    mem_op(1'b0, 2'b10, 1'b1, 32'h4000, 32'h0, 32'hDEAD_BEEF, 4, 4'b0000, 32'h0);
    check_eq("lw_stall_wdata", wdata_out, 32'hDEAD_BEEF);

    // Stores
    mem_op(1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 4'b1100, 32'hABCD_ABCD);
    check_eq("sh_valid", valid, 1);
    check_eq("sh_wreg", wreg_out, 0);
    check_eq("sh_wdata", wdata_out, 0);
    mem_op(1'b1, 2'b00, 1'b0, 32'h1001, 32'h0000_0012, 32'h0, 1, 4'b0010, 32'h1212_1212);
    mem_op(1'b1, 2'b10, 1'b0, 32'h0010, 32'hCAFE_F00D, 32'h0, 0, 4'b1111, 32'hCAFE_F00D);

    // Misaligned word load and double on a 32-bit datapath
    ex_valid = 1'b1; mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h3001;
    wd = 5'd9; wreg = 1'b1;
    step();
    mem_addr = 32'h0000_0008; mem_size = 2'b11;
    check_eq("mis_req", bus.dmem_req_o, 0);
    check_eq("mis_valid", valid, 1);
    check_eq("mis_ale", ale, 1);
    check_eq("mis_badv", badv, 32'h3001);
    check_eq("mis_wreg", wreg_out, 0);
    step();
    ex_valid = 1'b0; mem_en = 1'b0;
    check_eq("dbl32_req", bus.dmem_req_o, 0);
    check_eq("dbl32_ale", ale, 1);
    check_eq("dbl32_badv", badv, 32'h8);
    alu_op(5'd2, 32'h77);
    step();
    ex_valid = 1'b0;
    check_eq("post_ale_clear", ale, 0);
    step();

    // Output stall: WB not accepting holds the output and blocks EX
    wb_allowin = 1'b0;
    alu_op(5'd3, 32'h55);
    step();
    check_eq("stall_valid", valid, 1);
    alu_op(5'd4, 32'h66);
    #1;
    check_eq("stall_ready", ready, 0);
    repeat (2) step();
    check_eq("stall_hold_wd", wd_out, 3);
    check_eq("stall_hold_wdata", wdata_out, 32'h55);
    wb_allowin = 1'b1;
    #1;
    check_eq("unstall_ready", ready, 1);
    step();
    ex_valid = 1'b0;
    check_eq("unstall_wd", wd_out, 4);
    check_eq("unstall_wdata", wdata_out, 32'h66);
    step();
    check_eq("unstall_drain", valid, 0);

    // Reset while in RESP; a late data_ok must be discarded
    ex_valid = 1'b1; mem_en = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h40;
    step();
    ex_valid = 1'b0; mem_en = 1'b0; bus.dmem_addr_ok_i = 1'b1;
    step();
    bus.dmem_addr_ok_i = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; bus.dmem_data_ok_i = 1'b1; bus.dmem_rdata_i = 32'h1111_1111;
    check_eq("rstmid_req", bus.dmem_req_o, 0);
    step();
    bus.dmem_data_ok_i = 1'b0;
    check_eq("rstmid_valid", valid, 0);
    check_eq("rstmid_ready", ready, 1);

    // 64-bit datapath
    w_mem_op(1'b0, 2'b11, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0);
    check_eq("ld_valid", w_valid, 1);
    check_eq("ld_wd", w_wd_out, 12);
    check_eq("ld_wdata", w_wdata_out, 64'h0123_4567_89AB_CDEF);
    w_mem_op(1'b0, 2'b00, 32'h7, 64'h0, 64'hAB00_0000_0000_0000, 8'h00, 64'h0);
    check_eq("lbu64_wdata", w_wdata_out, 64'hAB);
    w_mem_op(1'b1, 2'b10, 32'h4, 64'h1111_2222_CAFE_F00D, 64'h0, 8'hF0, 64'hCAFE_F00D_CAFE_F00D);
    check_eq("sw64_wreg", w_wreg_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipelined memory-access stage between EX and WB. Carries the writeback triple (destination register, write enable, result) from EX to WB through an output register. Executes loads and stores against a split-handshake data-memory port: byte/half/word/double lanes, sign/zero extension, and misaligned-address detection. Data width and register-address width are parameters.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register/bus width; legal values 32 or 64.
- `ADDR_WIDTH`, 32: data-memory address width.
- `REG_ADDR_WIDTH`, 5: destination register index width.

Ports:
- `clk` in 1: the one clock.
- `rst` in 1: reset, synchronous, active-high.
- `ex_valid_i` in 1: EX presents an instruction.
- `ready_o` out 1: stage accepts this cycle. Transfer when `ex_valid_i & ready_o`.
- `wd_i` in REG_ADDR_WIDTH: destination register.
- `wreg_i` in 1: register write enable.
- `wdata_i` in DATA_WIDTH: ALU result, used by non-memory ops.
- `mem_en_i` in 1: instruction is a load or store.
- `mem_we_i` in 1: 1 = store, 0 = load.
- `mem_size_i` in 2: 00 byte, 01 half, 10 word, 11 double. 11 is legal only when DATA_WIDTH=64.
- `mem_signed_i` in 1: sign-extend the load result.
- `mem_addr_i` in ADDR_WIDTH: effective address.
- `mem_wdata_i` in DATA_WIDTH: store data, low-aligned.
- `dmem_req_o` out 1: request valid.
- `dmem_we_o` out 1: request is a write.
- `dmem_addr_o` out ADDR_WIDTH: request address.
- `dmem_wstrb_o` out DATA_WIDTH/8: byte write strobes.
- `dmem_wdata_o` out DATA_WIDTH: lane-replicated write data.
- `dmem_addr_ok_i` in 1: request accepted.
- `dmem_data_ok_i` in 1: read data valid, or write complete.
- `dmem_rdata_i` in DATA_WIDTH: read data.
- `wb_allowin_i` in 1: WB consumes the output this cycle.
- `valid_o` out 1: output register holds a completed instruction.
- `wd_o` out REG_ADDR_WIDTH: destination register to WB.
- `wreg_o` out 1: register write enable to WB.
- `wdata_o` out DATA_WIDTH: writeback data to WB.
- `ale_o` out 1: address-misaligned exception.
- `badv_o` out ADDR_WIDTH: faulting address; valid when `ale_o` is 1.

## Operation
- FSM states: IDLE, REQ, RESP.
- `ready_o` = (state==IDLE) & (~valid_o | wb_allowin_i). It is combinational.
- Output register: cleared when WB consumes (`valid_o & wb_allowin_i`) and nothing new completes.
- Output register: held while `valid_o & ~wb_allowin_i`.
- Non-memory op, or `mem_en_i`=0: next cycle `valid_o`=1, `wd_o`/`wreg_o`/`wdata_o` = inputs, `ale_o`=0.
- Alignment rule: address low bits must be zero for the size. Half: bit0. Word: bits[1:0]. Double: bits[2:0].
- Misaligned op, or size 11 at DATA_WIDTH=32: no bus request is issued.
- On a misaligned op, next cycle: `valid_o`=1, `ale_o`=1, `badv_o`=address, `wreg_o`=0.
- Aligned memory op: latch the op and go to REQ. `dmem_req_o` and its fields come from registers.
- REQ: hold `dmem_req_o`=1 and all fields stable until `dmem_addr_ok_i`, then go to RESP.
- RESP: wait for `dmem_data_ok_i`, then go to IDLE and load the output register.
  - Load: `wdata_o` = (`dmem_rdata_i` >> 8·offset) truncated to the size, then sign- or zero-extended. `wreg_o` = latched `wreg_i`.
  - Store: `wreg_o`=0, `wdata_o`=0.
  - Offset = addr mod (DATA_WIDTH/8).
- Store strobes: the size-wide mask shifted left by offset. Byte 0001, half 0011, word 1111 (DATA_WIDTH=32). `dmem_wdata_o` = the low size bytes of store data, replicated across all lanes.
- Load requests drive `dmem_wstrb_o`=0.
- The output register is always empty during REQ/RESP, because acceptance required it free. `data_ok` is therefore always captured.
- `dmem_data_ok_i` in IDLE or REQ is ignored. `dmem_addr_ok_i` outside REQ is ignored.
- One outstanding request at most.

## Timing
- Accept in cycle T.
- Non-memory or misaligned: `valid_o` at T+1.
- Memory op: `dmem_req_o` at T+1.
- With `addr_ok` at T+1 and `data_ok` at T+2, `valid_o` rises at T+3. Minimum memory-op latency is 3 cycles.
- Back-to-back non-memory ops with `wb_allowin_i`=1: one per cycle.
- Reset values: `valid_o`=0, `wd_o`=0, `wreg_o`=0, `wdata_o`=0, `ale_o`=0, `badv_o`=0, `dmem_req_o`=0, `dmem_we_o`=0, `dmem_addr_o`=0, `dmem_wstrb_o`=0, `dmem_wdata_o`=0, state IDLE.
- `ready_o` evaluates to 1 in the first cycle after reset.
- Reset mid-operation (REQ or RESP): next cycle is IDLE with `dmem_req_o`=0. Any late `data_ok` is discarded. The bus side must drop in-flight state on the same reset.

## Test plan
- Non-memory op: ALU op wd=5, wreg=1, wdata=0x1234, `wb_allowin_i`=1 -> next cycle `valid_o`=1, `wd_o`=5, `wdata_o`=0x1234. Three back-to-back ops -> three consecutive valid outputs.
- Signed byte load: addr 0x1003 signed byte, rdata 0x80_00_00_00, `addr_ok` T+1, `data_ok` T+2 -> `wdata_o`=0xFFFFFF80 at T+3. Unsigned -> 0x00000080.
- Half store: addr 0x2002 store half data 0xABCD -> `dmem_wstrb_o`=1100, `dmem_wdata_o`=0xABCDABCD. `wreg_o`=0 on completion.
- Misaligned word: word load at 0x3001 -> no `dmem_req_o`. Next cycle `ale_o`=1, `badv_o`=0x3001, `wreg_o`=0.
- Stalls: `addr_ok` delayed 4 cycles -> request fields stable throughout. `wb_allowin_i`=0 with `valid_o`=1 -> `ready_o`=0 and output held unchanged.
- Reset in RESP: then `data_ok`=1 next cycle -> `valid_o` stays 0, state IDLE, `ready_o`=1. At DATA_WIDTH=64, double load at 0x8 returns full rdata.
